// File: rtl/cgra_conf_loader_if.sv
// Valid/ready handshake carrying one packed PE configuration word into cgra_conf_loader.
interface cgra_conf_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/cgra_conf_loader.sv
// Serializes per-PE configuration words into framed header+payload bytes on conf_bus.
// Optional macro CGRA_CONF_CHECKSUM_EN appends an XOR checksum byte to every frame.
module cgra_conf_loader #(
  parameter int CONF_WIDTH   = 8,
  parameter int NUM_PE       = 9,
  parameter int WORDS_PER_PE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  cgra_conf_loader_if.slave     in_if,
  output logic [CONF_WIDTH-1:0] conf_bus,
  output logic                  busy,
  output logic                  done
);

  localparam int BYTE_W = (WORDS_PER_PE > 1) ? $clog2(WORDS_PER_PE) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(WORDS_PER_PE - 1);
  localparam logic [3:0]        LAST_PE   = 4'(NUM_PE - 1);

  typedef logic [WORDS_PER_PE-1:0][CONF_WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            pe_q, pe_d;
  logic [BYTE_W-1:0]     byte_q, byte_d;
  word_t                 word_q, word_d;
  logic [CONF_WIDTH-1:0] conf_d;
  logic [CONF_WIDTH-1:0] header;
  logic                  done_d;
  logic                  last_byte;
  logic                  last_pe;

  // in_ready deliberately ignores in_valid so the upstream sees a stable grant.
  assign in_if.in_ready = (state_q == ST_FETCH);
  assign busy           = (state_q != ST_IDLE);
  assign last_byte      = (byte_q == LAST_BYTE);
  assign last_pe        = (pe_q == LAST_PE);

  always_comb begin
    header             = '0;
    header[CONF_WIDTH-1] = 1'b1;
    header[3:0]        = pe_q;
  end

`ifdef CGRA_CONF_CHECKSUM_EN
  logic [CONF_WIDTH-1:0] checksum;

  always_comb begin
    checksum = header;
    for (int i = 0; i < WORDS_PER_PE; i++) begin
      checksum = checksum ^ word_q[i];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (in_if.in_valid) state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (last_byte) begin
`ifdef CGRA_CONF_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = last_pe ? ST_DONE : ST_FETCH;
`endif
          end
        end
        ST_CHECK: begin
          state_d = last_pe ? ST_DONE : ST_FETCH;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Byte stream and counters; conf_bus falls back to zero whenever nothing is framed.
  always_comb begin
    conf_d = '0;
    pe_d   = pe_q;
    byte_d = byte_q;
    word_d = word_q;
    done_d = 1'b0;
    if (abort) begin
      pe_d   = '0;
      byte_d = '0;
      word_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pe_d   = '0;
            byte_d = '0;
          end
        end
        ST_FETCH: begin
          if (in_if.in_valid) begin
            word_d = in_if.in_data;
            conf_d = header;
            byte_d = '0;
          end
        end
        ST_PAYLOAD: begin
          conf_d = word_q[byte_q];
          if (last_byte) begin
            byte_d = '0;
`ifndef CGRA_CONF_CHECKSUM_EN
            if (!last_pe) pe_d = pe_q + 4'd1;
`endif
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
        ST_CHECK: begin
`ifdef CGRA_CONF_CHECKSUM_EN
          conf_d = checksum;
`endif
          if (!last_pe) pe_d = pe_q + 4'd1;
        end
        ST_DONE: begin
          done_d = 1'b1;
        end
        default: begin
          conf_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conf_bus <= '0;
      pe_q     <= '0;
      byte_q   <= '0;
      word_q   <= '0;
      done     <= 1'b0;
    end else begin
      conf_bus <= conf_d;
      pe_q     <= pe_d;
      byte_q   <= byte_d;
      word_q   <= word_d;
      done     <= done_d;
    end
  end

endmodule
